// File: rtl/alu_master.sv
// alu_master: sequences one ALU transaction at a time.
// A request is latched, its operands are issued to the ALU (in one beat, or in two
// beats when split support is built in), the master waits a command-dependent
// latency, then captures RES and the flags and holds them until the response is taken.
// Optional feature: define ALU_MASTER_SPLIT_EN to enable two-beat (split) operand issue.
module alu_master #(
    parameter int WIDTH   = 8,
    parameter int LAT_STD = 1,
    parameter int LAT_MUL = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_mode,
    input  logic [3:0]         req_cmd,
    input  logic [WIDTH-1:0]   req_opa,
    input  logic [WIDTH-1:0]   req_opb,
    input  logic               req_cin,
    input  logic               req_split,
    output logic               CE,
    output logic               MODE,
    output logic [3:0]         CMD,
    output logic [WIDTH-1:0]   OPA,
    output logic [WIDTH-1:0]   OPB,
    output logic               CIN,
    output logic [1:0]         INP_VALID,
    input  logic [2*WIDTH-1:0] RES,
    input  logic               COUT,
    input  logic               OFLOW,
    input  logic               G,
    input  logic               L,
    input  logic               E,
    input  logic               ERR,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_res,
    output logic [5:0]         rsp_flags
);

    // A latency of 0 would never reach the capture point, so it is promoted to 1.
    localparam int LAT_STD_E = (LAT_STD < 1) ? 1 : LAT_STD;
    localparam int LAT_MUL_E = (LAT_MUL < 1) ? 1 : LAT_MUL;
    localparam int LAT_MAX   = (LAT_STD_E > LAT_MUL_E) ? LAT_STD_E : LAT_MUL_E;
    localparam int CNT_W     = $clog2(LAT_MAX + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, ISSUE_A, ISSUE_B, WAIT, RESP} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx, lat_load;
    logic               accept, is_mul;
    logic               ce_nx, mode_nx, cin_nx, rsp_valid_nx;
    logic [3:0]         cmd_nx;
    logic [WIDTH-1:0]   opa_nx, opb_nx, opb_hold, opb_hold_nx;
    logic [1:0]         inp_valid_nx;
    logic [2*WIDTH-1:0] rsp_res_nx;
    logic [5:0]         rsp_flags_nx;

`ifndef ALU_MASTER_SPLIT_EN
    logic unused_split;
    assign unused_split = req_split;
`endif

    // Ready is combinational on state so it drops the instant reset asserts and
    // is already high in the first cycle after reset is released.
    assign req_ready = (state == IDLE) && !RST;
    assign accept    = req_valid && req_ready;

    // MODE/CMD registers hold the latched request, so they select the latency.
    assign is_mul   = MODE && ((CMD == 4'd9) || (CMD == 4'd10));
    assign lat_load = is_mul ? CNT_W'(LAT_MUL_E) : CNT_W'(LAT_STD_E);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        ce_nx        = CE;
        mode_nx      = MODE;
        cmd_nx       = CMD;
        opa_nx       = OPA;
        opb_nx       = OPB;
        cin_nx       = CIN;
        inp_valid_nx = 2'b00;
        opb_hold_nx  = opb_hold;
        rsp_valid_nx = rsp_valid;
        rsp_res_nx   = rsp_res;
        rsp_flags_nx = rsp_flags;
        case (state)
            IDLE: begin
                ce_nx = 1'b0;
                if (accept) begin
                    ce_nx   = 1'b1;
                    mode_nx = req_mode;
                    cmd_nx  = req_cmd;
                    cin_nx  = req_cin;
                    opa_nx  = req_opa;
`ifdef ALU_MASTER_SPLIT_EN
                    opb_hold_nx = req_opb;
                    if (req_split) begin
                        state_nx     = ISSUE_A;
                        opb_nx       = '0;
                        inp_valid_nx = 2'b01;
                    end else begin
                        state_nx     = ISSUE;
                        opb_nx       = req_opb;
                        inp_valid_nx = 2'b11;
                    end
`else
                    state_nx     = ISSUE;
                    opb_nx       = req_opb;
                    inp_valid_nx = 2'b11;
`endif
                end
            end
            ISSUE: begin
                state_nx = WAIT;
                cnt_nx   = lat_load;
                ce_nx    = 1'b1;
            end
`ifdef ALU_MASTER_SPLIT_EN
            ISSUE_A: begin
                state_nx     = ISSUE_B;
                ce_nx        = 1'b1;
                opb_nx       = opb_hold;
                inp_valid_nx = 2'b10;
            end
            ISSUE_B: begin
                state_nx = WAIT;
                cnt_nx   = lat_load;
                ce_nx    = 1'b1;
            end
`endif
            WAIT: begin
                ce_nx = 1'b1;
                if (cnt <= CNT_W'(1)) begin
                    // Last latency cycle: this edge samples the ALU result.
                    state_nx     = RESP;
                    cnt_nx       = '0;
                    ce_nx        = 1'b0;
                    rsp_valid_nx = 1'b1;
                    rsp_res_nx   = RES;
                    rsp_flags_nx = {COUT, OFLOW, G, L, E, ERR};
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                ce_nx = 1'b0;
                if (rsp_ready) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
                ce_nx    = 1'b0;
            end
        endcase
    end

    // Output, counter and operand-hold registers; reset clears all of them.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt       <= '0;
            CE        <= 1'b0;
            MODE      <= 1'b0;
            CMD       <= '0;
            OPA       <= '0;
            OPB       <= '0;
            CIN       <= 1'b0;
            INP_VALID <= 2'b00;
            opb_hold  <= '0;
            rsp_valid <= 1'b0;
            rsp_res   <= '0;
            rsp_flags <= '0;
        end else begin
            cnt       <= cnt_nx;
            CE        <= ce_nx;
            MODE      <= mode_nx;
            CMD       <= cmd_nx;
            OPA       <= opa_nx;
            OPB       <= opb_nx;
            CIN       <= cin_nx;
            INP_VALID <= inp_valid_nx;
            opb_hold  <= opb_hold_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_res   <= rsp_res_nx;
            rsp_flags <= rsp_flags_nx;
        end
    end

endmodule

// File: tb/tb_alu_master.sv
// Bench for alu_master: table vectors, randomized transactions and hand-written
// reset sequences. The bench plays the ALU: it presents the correct result only in
// the one cycle whose closing edge should capture it, and inverted data otherwise.
module tb_alu_master;

    localparam int WIDTH   = 8;
    localparam int LAT_STD = 1;
    localparam int LAT_MUL = 2;
`ifdef ALU_MASTER_SPLIT_EN
    localparam bit SPLIT_ON = 1'b1;
`else
    localparam bit SPLIT_ON = 1'b0;
`endif

    logic               CLK, RST;
    logic               req_valid, req_ready, req_mode, req_cin, req_split;
    logic [3:0]         req_cmd;
    logic [WIDTH-1:0]   req_opa, req_opb;
    logic               CE, MODE, CIN;
    logic [3:0]         CMD;
    logic [WIDTH-1:0]   OPA, OPB;
    logic [1:0]         INP_VALID;
    logic [2*WIDTH-1:0] RES;
    logic               COUT, OFLOW, G, L, E, ERR;
    logic               rsp_valid, rsp_ready;
    logic [2*WIDTH-1:0] rsp_res;
    logic [5:0]         rsp_flags;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        mode;
        logic [3:0]  cmd;
        logic [7:0]  opa;
        logic [7:0]  opb;
        logic        cin;
        logic        split;
        int          hold;
        int          lat;
        logic [15:0] exp_res;
    } vec_t;

    alu_master #(.WIDTH(WIDTH), .LAT_STD(LAT_STD), .LAT_MUL(LAT_MUL)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_cmd(req_cmd), .req_opa(req_opa), .req_opb(req_opb),
        .req_cin(req_cin), .req_split(req_split),
        .CE(CE), .MODE(MODE), .CMD(CMD), .OPA(OPA), .OPB(OPB), .CIN(CIN),
        .INP_VALID(INP_VALID), .RES(RES),
        .COUT(COUT), .OFLOW(OFLOW), .G(G), .L(L), .E(E), .ERR(ERR),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_flags(rsp_flags)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Stand-in ALU behaviour: returns {flags[5:0], res[15:0]}.
    function automatic logic [21:0] alu_ref(input logic m, input logic [3:0] c,
                                            input logic [7:0] a, input logic [7:0] b,
                                            input logic ci);
        logic [15:0] ea, eb, r;
        logic [5:0]  f;
        ea = {8'h00, a};
        eb = {8'h00, b};
        r  = '0;
        if (m) begin
            case (c)
                4'd0:    r = ea + eb;
                4'd1:    r = ea - eb;
                4'd2:    r = ea + eb + {15'd0, ci};
                4'd9:    r = (ea + 16'd1) * (eb + 16'd1);
                4'd10:   r = (ea + ea) * eb;
                default: r = {a, b};
            endcase
        end else begin
            case (c)
                4'd0:    r = {8'h00, a & b};
                4'd1:    r = {8'h00, ~(a | b)};
                4'd2:    r = {8'h00, a | b};
                4'd3:    r = {8'h00, a ^ b};
                default: r = {8'h00, ~(a ^ b)};
            endcase
        end
        f = {r[8], ^r, a > b, a < b, a == b, c > 4'd13};
        return {f, r};
    endfunction

    function automatic int lat_of(input logic m, input logic [3:0] c);
        int ls, lm;
        ls = (LAT_STD < 1) ? 1 : LAT_STD;
        lm = (LAT_MUL < 1) ? 1 : LAT_MUL;
        return (m && (c == 4'd9 || c == 4'd10)) ? lm : ls;
    endfunction

    // One complete transaction, checked cycle by cycle against the expected timeline.
    task automatic run_txn(input vec_t v, input logic [15:0] er, input int lat);
        int          ni, wcnt, last;
        logic [21:0] ref_out, alu_out;
        logic [7:0]  sa, sb;
        logic [3:0]  scmd;
        logic        sm, sc;
        logic [1:0]  eiv;
        logic [7:0]  eopb;
        ni      = (SPLIT_ON && v.split) ? 2 : 1;
        ref_out = alu_ref(v.mode, v.cmd, v.opa, v.opb, v.cin);
        alu_out = '0;
        sa = '0; sb = '0; scmd = '0; sm = 1'b0; sc = 1'b0;
        req_mode = v.mode; req_cmd = v.cmd; req_opa = v.opa; req_opb = v.opb;
        req_cin = v.cin; req_split = v.split; req_valid = 1'b1;
        chk("offer_ready", 32'(req_ready), 32'd1);
        wcnt = 0;
        while (!req_ready && wcnt < 20) begin
            tick();
            wcnt++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(wcnt), 32'd0);
            req_valid = 1'b0;
            return;
        end
        tick();
        // Keep offering garbage: it must be ignored while busy.
        req_mode = ~v.mode; req_cmd = ~v.cmd; req_opa = ~v.opa; req_opb = ~v.opb;
        req_cin = ~v.cin;
        last = ni + lat + 1 + v.hold;
        for (int k = 1; k <= last; k++) begin
            if (k <= ni) begin
                eiv  = (ni == 1) ? 2'b11 : ((k == 1) ? 2'b01 : 2'b10);
                eopb = (ni == 2 && k == 1) ? 8'h00 : v.opb;
                chk("iss_ce", 32'(CE), 32'd1);
                chk("iss_inp_valid", 32'(INP_VALID), 32'(eiv));
                chk("iss_mode", 32'(MODE), 32'(v.mode));
                chk("iss_cmd", 32'(CMD), 32'(v.cmd));
                chk("iss_cin", 32'(CIN), 32'(v.cin));
                chk("iss_opa", 32'(OPA), 32'(v.opa));
                chk("iss_opb", 32'(OPB), 32'(eopb));
                chk("iss_req_ready", 32'(req_ready), 32'd0);
                if (INP_VALID[0]) sa = OPA;
                if (INP_VALID[1]) sb = OPB;
                sm = MODE; scmd = CMD; sc = CIN;
                alu_out = alu_ref(sm, scmd, sa, sb, sc);
            end else if (k <= ni + lat) begin
                chk("wait_ce", 32'(CE), 32'd1);
                chk("wait_inp_valid", 32'(INP_VALID), 32'd0);
                chk("wait_mode", 32'(MODE), 32'(v.mode));
                chk("wait_cmd", 32'(CMD), 32'(v.cmd));
                chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("wait_req_ready", 32'(req_ready), 32'd0);
            end else begin
                chk("resp_valid", 32'(rsp_valid), 32'd1);
                chk("resp_res", 32'(rsp_res), 32'(er));
                chk("resp_flags", 32'(rsp_flags), 32'(ref_out[21:16]));
                chk("resp_ce", 32'(CE), 32'd0);
                chk("resp_inp_valid", 32'(INP_VALID), 32'd0);
                chk("resp_req_ready", 32'(req_ready), 32'd0);
            end
            if (k == ni + lat) {COUT, OFLOW, G, L, E, ERR, RES} = alu_out;
            else               {COUT, OFLOW, G, L, E, ERR, RES} = ~alu_out;
            rsp_ready = (k == last);
            tick();
        end
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
        chk("post_ce", 32'(CE), 32'd0);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        logic [21:0] ro;
        RST = 1'b1;
        req_valid = 1'b0; req_mode = 1'b0; req_cmd = '0; req_opa = '0; req_opb = '0;
        req_cin = 1'b0; req_split = 1'b0; rsp_ready = 1'b0;
        RES = '0; {COUT, OFLOW, G, L, E, ERR} = 6'd0;

        tbl[0] = '{mode:1'b1, cmd:4'd0,  opa:8'h0F, opb:8'h01, cin:1'b0, split:1'b0, hold:0, lat:1, exp_res:16'h0010};
        tbl[1] = '{mode:1'b1, cmd:4'd9,  opa:8'h03, opb:8'h04, cin:1'b0, split:1'b0, hold:0, lat:2, exp_res:16'h0014};
        tbl[2] = '{mode:1'b0, cmd:4'd1,  opa:8'hF0, opb:8'h0F, cin:1'b0, split:1'b1, hold:0, lat:1, exp_res:16'h0000};
        tbl[3] = '{mode:1'b1, cmd:4'd2,  opa:8'h80, opb:8'h7F, cin:1'b1, split:1'b0, hold:5, lat:1, exp_res:16'h0100};
        tbl[4] = '{mode:1'b1, cmd:4'd10, opa:8'h05, opb:8'h06, cin:1'b0, split:1'b0, hold:1, lat:2, exp_res:16'h003C};
        tbl[5] = '{mode:1'b0, cmd:4'd10, opa:8'h33, opb:8'h0F, cin:1'b0, split:1'b0, hold:0, lat:1, exp_res:16'h00C3};
        tbl[6] = '{mode:1'b1, cmd:4'd1,  opa:8'h01, opb:8'h02, cin:1'b0, split:1'b0, hold:2, lat:1, exp_res:16'hFFFF};
        tbl[7] = '{mode:1'b1, cmd:4'd9,  opa:8'h00, opb:8'hFF, cin:1'b0, split:1'b1, hold:0, lat:2, exp_res:16'h0100};

        // Power-on reset
        tick(); tick();
        chk("reset_outputs", 32'({CE, MODE, CMD, OPA, OPB, CIN, INP_VALID, rsp_valid}), 32'd0);
        chk("reset_rsp_res", 32'(rsp_res), 32'd0);
        chk("reset_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        #3 RST = 1'b0;
        #1 chk("release_req_ready", 32'(req_ready), 32'd1);

        // Table vectors, back to back
        for (int i = 0; i < 8; i++) run_txn(tbl[i], tbl[i].exp_res, tbl[i].lat);

        // Reset asserted mid-WAIT discards the transaction
        req_mode = 1'b1; req_cmd = 4'd9; req_opa = 8'h03; req_opb = 8'h04;
        req_cin = 1'b0; req_split = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("midrst_wait_ce", 32'(CE), 32'd1);
        chk("midrst_wait_mode_cmd", 32'({MODE, CMD}), 32'h19);
        #3 RST = 1'b1;
        #1;
        chk("midrst_outputs", 32'({CE, MODE, CMD, OPA, OPB, CIN, INP_VALID, rsp_valid}), 32'd0);
        chk("midrst_rsp_res", 32'(rsp_res), 32'd0);
        chk("midrst_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        tick(); tick();
        #3 RST = 1'b0;
        #1 chk("midrst_release_ready", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("midrst_idle_ce", 32'(CE), 32'd0);
            chk("midrst_idle_ready", 32'(req_ready), 32'd1);
        end
        rsp_ready = 1'b0;
        run_txn(tbl[1], tbl[1].exp_res, tbl[1].lat);

        // Randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            rv.mode  = 1'($urandom);
            rv.cmd   = 4'($urandom_range(0, 15));
            rv.opa   = 8'($urandom);
            rv.opb   = 8'($urandom);
            rv.cin   = 1'($urandom);
            rv.split = 1'($urandom);
            rv.hold  = int'($urandom_range(0, 3));
            rv.lat   = 0;
            rv.exp_res = '0;
            ro = alu_ref(rv.mode, rv.cmd, rv.opa, rv.opb, rv.cin);
            run_txn(rv, ro[15:0], lat_of(rv.mode, rv.cmd));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
